// File: rtl/sec_a2b_serial.sv
// sec_a2b_serial: masked arithmetic-to-Boolean share conversion, bit-serial DOM adder
//   Parameters: K_WIDTH (share width), N_SHARES (2..8 shares)
//   Ports: clk, rst_n (async active-low), dvld (input valid), ena (global enable),
//          i_a (arithmetic shares), rnd (fresh randomness), o_z (Boolean shares),
//          ovld (one-cycle result pulse), busy (conversion in progress)
//   Optional debug: define SEC_A2B_UNMASK_CHK_EN to add dbg_err (unmasked check, never for secure builds)
module sec_a2b_serial #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dvld,
  input  logic                            ena,
  input  logic [K_WIDTH*N_SHARES-1:0]     i_a,
  input  logic [K_WIDTH*(N_SHARES-1)-1:0] rnd,
  output logic [K_WIDTH*N_SHARES-1:0]     o_z,
  output logic                            ovld,
  output logic                            busy
`ifdef SEC_A2B_UNMASK_CHK_EN
  , output logic                          dbg_err
`endif
);
  localparam int BW = K_WIDTH > 1 ? $clog2(K_WIDTH) : 1;
  localparam int IW = $clog2(N_SHARES) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(K_WIDTH - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SHARES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REFRESH, S_ADD, S_DONE} state_t;

  state_t                        r_state;
  logic [K_WIDTH*N_SHARES-1:0]   r_a;
  logic [K_WIDTH-1:0]            r_z [N_SHARES];
  logic [K_WIDTH-1:0]            r_y;
  logic [N_SHARES-1:0]           r_c;
  logic [IW-1:0]                 r_idx;
  logic [BW-1:0]                 r_bit;
  logic [K_WIDTH*N_SHARES-1:0]   r_oz;
  logic                          r_ovld;
  logic [K_WIDTH-1:0]            w_rx;
  logic [N_SHARES-1:0]           w_s;
  logic [N_SHARES-1:0]           w_x;
  logic [N_SHARES-1:0]           w_w;
  logic [N_SHARES-1:0]           w_c_nxt;

  assign o_z  = r_oz;
  assign ovld = r_ovld;
  assign busy = r_state != S_IDLE;

  // Share 0 absorbs the XOR of all refresh words so the sharing stays consistent.
  always_comb begin
    w_rx = '0;
    for (int k = 1; k < N_SHARES; k++) w_rx = w_rx ^ rnd[(k-1)*K_WIDTH +: K_WIDTH];
  end

  // Current bit sits at the LSB of each z share; y is only nonzero in share 0.
  always_comb begin
    for (int k = 0; k < N_SHARES; k++) begin
      w_x[k] = r_z[k][0] ^ r_c[k];
      w_w[k] = (k == 0 ? r_y[0] : 1'b0) ^ r_c[k];
      w_s[k] = r_z[k][0] ^ (k == 0 ? r_y[0] : 1'b0) ^ r_c[k];
    end
  end

  // DOM AND: each unordered share pair (i,j) gets its own fresh bit, shared by
  // both cross terms so it cancels in the XOR of the result.
  always_comb begin
    for (int i = 0; i < N_SHARES; i++) w_c_nxt[i] = (w_x[i] & w_w[i]) ^ r_c[i];
    for (int i = 0; i < N_SHARES; i++)
      for (int j = i + 1; j < N_SHARES; j++) begin
        w_c_nxt[i] = w_c_nxt[i] ^ (w_x[i] & w_w[j]) ^ rnd[i*N_SHARES - i*(i+1)/2 + j - i - 1];
        w_c_nxt[j] = w_c_nxt[j] ^ (w_x[j] & w_w[i]) ^ rnd[i*N_SHARES - i*(i+1)/2 + j - i - 1];
      end
  end

`ifdef SEC_A2B_UNMASK_CHK_EN
  logic [K_WIDTH-1:0] w_sum;
  logic [K_WIDTH-1:0] w_zx;
  always_comb begin
    w_sum = '0;
    w_zx  = '0;
    for (int k = 0; k < N_SHARES; k++) begin
      w_sum = w_sum + r_a[k*K_WIDTH +: K_WIDTH];
      w_zx  = w_zx ^ r_z[k];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_y     <= '0;
      r_c     <= '0;
      r_idx   <= '0;
      r_bit   <= '0;
      r_oz    <= '0;
      r_ovld  <= 1'b0;
      for (int k = 0; k < N_SHARES; k++) r_z[k] <= '0;
`ifdef SEC_A2B_UNMASK_CHK_EN
      dbg_err <= 1'b0;
`endif
    end else if (ena) begin
      r_ovld <= r_state == S_DONE;
      case (r_state)
        S_IDLE: if (dvld) begin
          r_a     <= i_a;
          r_z[0]  <= i_a[0 +: K_WIDTH];
          for (int k = 1; k < N_SHARES; k++) r_z[k] <= '0;
          r_idx   <= IW'(1);
          r_state <= S_REFRESH;
        end
        S_REFRESH: begin
          r_z[0] <= r_z[0] ^ w_rx;
          for (int k = 1; k < N_SHARES; k++) r_z[k] <= r_z[k] ^ rnd[(k-1)*K_WIDTH +: K_WIDTH];
          r_y     <= r_a[r_idx*K_WIDTH +: K_WIDTH];
          r_c     <= '0;
          r_bit   <= '0;
          r_state <= S_ADD;
        end
        S_ADD: begin
          // Sum bits enter at the MSB; after K_WIDTH shifts the word is realigned.
          for (int k = 0; k < N_SHARES; k++) r_z[k] <= {w_s[k], r_z[k][K_WIDTH-1:1]};
          r_y   <= r_y >> 1;
          r_c   <= w_c_nxt;
          r_bit <= r_bit + 1'b1;
          if (r_bit == LAST_BIT) begin
            r_idx   <= r_idx + 1'b1;
            r_state <= r_idx == LAST_IDX ? S_DONE : S_REFRESH;
          end
        end
        default: begin
          for (int k = 0; k < N_SHARES; k++) r_oz[k*K_WIDTH +: K_WIDTH] <= r_z[k];
`ifdef SEC_A2B_UNMASK_CHK_EN
          dbg_err <= w_zx != w_sum;
`endif
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
